// File: rtl/sift_pkg.sv
// sift_pkg: shared defaults, FSM state type and rounding average for the SIFT pyramid blocks
package sift_pkg;
  localparam int DW_DEF = 8;
  localparam int IN_WIDTH_DEF = 128;
  localparam int IN_HEIGHT_DEF = 128;
  typedef enum logic [1:0] {FILL, FLUSH, REPLAY} state_t;
  function automatic logic [31:0] rnd_avg(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + 33'd1;
    return s[32:1];
  endfunction
endpackage

// File: rtl/sift_line_buffer.sv
// sift_line_buffer: simple dual-port RAM with a registered read, one row deep
module sift_line_buffer #(
  parameter int DEPTH = 128,
  parameter int DW = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          iclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge iclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/up_sample_2x.sv
// up_sample_2x: 2x upsampler, linear interpolation across a row and row repetition down the frame
module up_sample_2x
  import sift_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int IN_HEIGHT = IN_HEIGHT_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic          iDval,
  input  logic [DW-1:0] iData,
  output logic          oRdy,
  output logic          oData_en,
  output logic [DW-1:0] oData,
  output logic          oFrame_done
);
  localparam int CW = $clog2(IN_WIDTH);
  localparam int RW = $clog2(IN_HEIGHT + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] RLAST = RW'(IN_HEIGHT - 1);
  state_t st, st_n;
  logic [CW-1:0] col, col_n, k, k_n, raddr;
  logic [RW-1:0] row, row_n;
  logic [1:0] fc, fc_n;
  logic rp, rp_n, half, half_n, rdy_n, en_n, done_n, acc;
  logic [DW-1:0] prev, prev_n, cur, cur_n, dat_n, rdata;
  function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return DW'(rnd_avg(32'(a), 32'(b)));
  endfunction
  assign acc = iDval && oRdy;
  // replay reads one pixel ahead so p[k+1] is ready for the odd output
  assign raddr = st != REPLAY ? '0 : k == LAST ? k : k + CW'(1);
  sift_line_buffer #(.DEPTH(IN_WIDTH), .DW(DW), .AW(CW)) u_lbuf (
    .iclk(iclk), .we(acc), .waddr(col), .wdata(iData), .raddr(raddr), .rdata(rdata)
  );
  always_comb begin
    st_n = st;
    col_n = col;
    row_n = row;
    k_n = k;
    rp_n = rp;
    fc_n = fc;
    half_n = 1'b0;
    prev_n = prev;
    cur_n = cur;
    rdy_n = 1'b0;
    en_n = 1'b0;
    dat_n = oData;
    done_n = 1'b0;
    case (st)
      FILL: begin
        if (acc) begin
          cur_n = iData;
          col_n = col == LAST ? '0 : col + CW'(1);
          if (col == '0) prev_n = iData;
          else begin
            en_n = 1'b1;
            dat_n = prev;
            half_n = 1'b1;
          end
          if (col == LAST) begin
            st_n = FLUSH;
            fc_n = 2'd0;
          end
        end else begin
          rdy_n = 1'b1;
          if (half) begin
            en_n = 1'b1;
            dat_n = avg(prev, cur);
            prev_n = cur;
          end
        end
      end
      FLUSH: begin
        en_n = 1'b1;
        fc_n = fc + 2'd1;
        dat_n = fc == 2'd0 ? avg(prev, cur) : cur;
        if (fc == 2'd2) begin
          prev_n = rdata;
          st_n = REPLAY;
          k_n = '0;
          rp_n = 1'b0;
        end
      end
      REPLAY: begin
        en_n = 1'b1;
        rp_n = ~rp;
        if (!rp) dat_n = prev;
        else begin
          dat_n = k == LAST ? prev : avg(prev, rdata);
          prev_n = rdata;
          k_n = k + CW'(1);
          if (k == LAST) begin
            st_n = FILL;
            k_n = '0;
            row_n = row == RLAST ? '0 : row + RW'(1);
            done_n = row == RLAST;
          end
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      st <= FILL;
      col <= '0;
      row <= '0;
      k <= '0;
      rp <= 1'b0;
      fc <= 2'd0;
      half <= 1'b0;
      prev <= '0;
      cur <= '0;
      oRdy <= 1'b0;
      oData_en <= 1'b0;
      oData <= '0;
      oFrame_done <= 1'b0;
    end else begin
      st <= st_n;
      col <= col_n;
      row <= row_n;
      k <= k_n;
      rp <= rp_n;
      fc <= fc_n;
      half <= half_n;
      prev <= prev_n;
      cur <= cur_n;
      oRdy <= rdy_n;
      oData_en <= en_n;
      oData <= dat_n;
      oFrame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_up_sample_2x.sv
// tb_up_sample_2x: randomized row stimulus checked against an arithmetic model of the upsampled row
module tb_up_sample_2x;
  localparam int W = 4, H = 2, DW = 8, N = 80;
  logic iclk = 1'b0, irst_n = 1'b0, iDval = 1'b0;
  logic [DW-1:0] iData = '0;
  logic oRdy, oData_en, oFrame_done;
  logic [DW-1:0] oData;
  int n_chk = 0, n_fail = 0, frame_row = 0;
  logic [DW-1:0] px [W];
  logic en_log [N], rdy_log [N], done_log [N], acc_log [N];
  logic [DW-1:0] dat_log [N];
  int got[$], out_at[$], acc_at[$], exp_q[$];
  int n_done, done_idx;
  logic rdy_tail;

  up_sample_2x #(.IN_WIDTH(W), .IN_HEIGHT(H), .DW(DW)) dut (
    .iclk(iclk), .irst_n(irst_n), .iDval(iDval), .iData(iData),
    .oRdy(oRdy), .oData_en(oData_en), .oData(oData), .oFrame_done(oFrame_done)
  );

  always #5 iclk = ~iclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // expected stream for one input row: the interpolated row, then the same row again
  task automatic build_exp();
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < W; j++) begin
        exp_q.push_back(int'(px[j]));
        exp_q.push_back(j < W - 1 ? (int'(px[j]) + int'(px[j+1]) + 1) / 2 : int'(px[W-1]));
      end
  endtask

  task automatic run_row(input bit stall);
    fork
      begin
        int i = 0;
        logic a;
        for (int c = 0; c < N && i < W; c++) begin
          iDval = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          iData = px[i];
          @(negedge iclk);
          a = iDval && oRdy;
          @(posedge iclk);
          #1;
          if (a) i++;
        end
        iDval = 1'b0;
      end
      begin
        for (int c = 0; c < N; c++) begin
          @(negedge iclk);
          en_log[c] = oData_en;
          rdy_log[c] = oRdy;
          done_log[c] = oFrame_done;
          dat_log[c] = oData;
          acc_log[c] = iDval && oRdy;
        end
      end
    join
    @(posedge iclk);
    #1;
    got.delete(); out_at.delete(); acc_at.delete();
    n_done = 0; done_idx = -1; rdy_tail = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (acc_log[c]) acc_at.push_back(c);
      if (en_log[c]) begin
        got.push_back(int'(dat_log[c]));
        out_at.push_back(c);
      end
      if (done_log[c]) begin
        n_done++;
        done_idx = en_log[c] ? got.size() - 1 : -1;
      end
    end
    if (acc_at.size() > 0 && out_at.size() > 0)
      for (int c = acc_at[$] + 1; c <= out_at[$]; c++) rdy_tail |= rdy_log[c];
  endtask

  task automatic test_reset();
    irst_n = 1'b0;
    repeat (3) @(negedge iclk);
    n_chk += 4;
    if (oRdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", oRdy); end
    if (oData_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", oData_en); end
    if (oData !== '0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", oData); end
    if (oFrame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", oFrame_done); end
    irst_n = 1'b1;
    #1;
    n_chk++;
    if (oRdy !== 1'b0) begin n_fail++; $display("FAIL release_rdy_early: got %b expected 0", oRdy); end
    @(negedge iclk);
    n_chk += 2;
    if (oRdy !== 1'b1) begin n_fail++; $display("FAIL release_rdy: got %b expected 1", oRdy); end
    if (oData_en !== 1'b0) begin n_fail++; $display("FAIL release_en: got %b expected 0", oData_en); end
    @(posedge iclk);
    #1;
  endtask

  task automatic test_basic_row();
    int last;
    px = '{8'd10, 8'd20, 8'd30, 8'd41};
    build_exp();
    run_row(1'b0);
    n_chk++;
    if (got.size() != 4 * W) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got.size(), 4 * W); end
    for (int j = 0; j < exp_q.size(); j++) begin
      n_chk++;
      if (j >= got.size() || got[j] != exp_q[j]) begin
        n_fail++;
        $display("FAIL basic_pix[%0d]: got %0d expected %0d", j, j < got.size() ? got[j] : -1, exp_q[j]);
      end
    end
    n_chk++;
    if (acc_at.size() != W) begin n_fail++; $display("FAIL basic_accepts: got %0d expected %0d", acc_at.size(), W); end
    for (int j = 1; j < acc_at.size(); j++) begin
      n_chk++;
      if (acc_at[j] - acc_at[j-1] != 2) begin
        n_fail++;
        $display("FAIL basic_accept_gap[%0d]: got %0d expected 2", j, acc_at[j] - acc_at[j-1]);
      end
    end
    if (acc_at.size() == W && out_at.size() == 4 * W) begin
      last = out_at[$];
      n_chk += 6;
      if (out_at[0] != acc_at[1] + 1) begin n_fail++; $display("FAIL basic_first_out: got cycle %0d expected %0d", out_at[0], acc_at[1] + 1); end
      if (last - out_at[0] != 4 * W - 1) begin n_fail++; $display("FAIL basic_contiguous: got span %0d expected %0d", last - out_at[0], 4 * W - 1); end
      if (last != acc_at[W-1] + 4 + 2 * W) begin n_fail++; $display("FAIL basic_last_out: got cycle %0d expected %0d", last, acc_at[W-1] + 4 + 2 * W); end
      if (rdy_tail !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_low: got %b expected 0", rdy_tail); end
      if (rdy_log[last+1] !== 1'b1) begin n_fail++; $display("FAIL basic_rdy_return: got %b expected 1", rdy_log[last+1]); end
      if (dat_log[last+5] !== px[W-1]) begin n_fail++; $display("FAIL basic_data_hold: got %0d expected %0d", dat_log[last+5], px[W-1]); end
    end
    n_chk++;
    if (n_done != 0) begin n_fail++; $display("FAIL basic_no_done: got %0d expected 0", n_done); end
    frame_row = (frame_row + 1) % H;
  endtask

  task automatic test_rounding();
    px = '{8'd255, 8'd254, 8'd0, 8'd1};
    build_exp();
    run_row(1'b0);
    n_chk++;
    if (got.size() != 4 * W) begin n_fail++; $display("FAIL round_count: got %0d expected %0d", got.size(), 4 * W); end
    for (int j = 0; j < exp_q.size(); j++) begin
      n_chk++;
      if (j >= got.size() || got[j] != exp_q[j]) begin
        n_fail++;
        $display("FAIL round_pix[%0d]: got %0d expected %0d", j, j < got.size() ? got[j] : -1, exp_q[j]);
      end
    end
    n_chk += 2;
    if (n_done != (frame_row == H - 1 ? 1 : 0)) begin n_fail++; $display("FAIL round_done_count: got %0d expected %0d", n_done, frame_row == H - 1 ? 1 : 0); end
    if (frame_row == H - 1 && done_idx != 4 * W - 1) begin n_fail++; $display("FAIL round_done_pos: got %0d expected %0d", done_idx, 4 * W - 1); end
    frame_row = (frame_row + 1) % H;
  endtask

  task automatic test_frame_end();
    int total, dones, last_val, bad;
    px = '{8'd1, 8'd2, 8'd3, 8'd4};
    build_exp();
    run_row(1'b0);
    bad = 0;
    for (int j = 0; j < exp_q.size(); j++) if (j >= got.size() || got[j] != exp_q[j]) bad++;
    total = got.size();
    dones = n_done;
    frame_row = (frame_row + 1) % H;
    px = '{8'd8, 8'd8, 8'd8, 8'd8};
    build_exp();
    run_row(1'b0);
    for (int j = 0; j < exp_q.size(); j++) if (j >= got.size() || got[j] != exp_q[j]) bad++;
    total += got.size();
    dones += n_done;
    last_val = got.size() > 0 ? got[$] : -1;
    n_chk += 5;
    if (bad != 0) begin n_fail++; $display("FAIL frame_pixels: got %0d wrong pixels expected 0", bad); end
    if (total != 8 * W) begin n_fail++; $display("FAIL frame_count: got %0d expected %0d", total, 8 * W); end
    if (dones != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d expected 1", dones); end
    if (done_idx != 4 * W - 1) begin n_fail++; $display("FAIL frame_done_pos: got %0d expected %0d", done_idx, 4 * W - 1); end
    if (last_val != 8) begin n_fail++; $display("FAIL frame_last_val: got %0d expected 8", last_val); end
    frame_row = (frame_row + 1) % H;
    for (int j = 0; j < W; j++) px[j] = DW'($urandom);
    build_exp();
    run_row(1'b0);
    n_chk += 3;
    if (acc_at.size() != W) begin n_fail++; $display("FAIL next_frame_accepts: got %0d expected %0d", acc_at.size(), W); end
    if (n_done != 0) begin n_fail++; $display("FAIL next_frame_done: got %0d expected 0", n_done); end
    if (got.size() != 4 * W || got[0] != exp_q[0] || got[$] != exp_q[$]) begin
      n_fail++;
      $display("FAIL next_frame_row: got %0d outputs expected %0d", got.size(), 4 * W);
    end
    frame_row = (frame_row + 1) % H;
  endtask

  task automatic test_stall();
    for (int r = 0; r < 4; r++) begin
      if (r == 0) px = '{8'd10, 8'd20, 8'd30, 8'd41};
      else for (int j = 0; j < W; j++) px[j] = DW'($urandom);
      build_exp();
      run_row(1'b1);
      for (int j = 0; j < exp_q.size(); j++) begin
        n_chk++;
        if (j >= got.size() || got[j] != exp_q[j]) begin
          n_fail++;
          $display("FAIL stall%0d_pix[%0d]: got %0d expected %0d", r, j, j < got.size() ? got[j] : -1, exp_q[j]);
        end
      end
      n_chk += 4;
      if (got.size() != 4 * W) begin n_fail++; $display("FAIL stall%0d_count: got %0d expected %0d", r, got.size(), 4 * W); end
      if (acc_at.size() != W) begin n_fail++; $display("FAIL stall%0d_accepts: got %0d expected %0d", r, acc_at.size(), W); end
      if (rdy_tail !== 1'b0) begin n_fail++; $display("FAIL stall%0d_rdy_low: got %b expected 0", r, rdy_tail); end
      if (n_done != (frame_row == H - 1 ? 1 : 0)) begin n_fail++; $display("FAIL stall%0d_done: got %0d expected %0d", r, n_done, frame_row == H - 1 ? 1 : 0); end
      frame_row = (frame_row + 1) % H;
    end
  endtask

  task automatic test_mid_reset();
    int i = 0, seen = 0;
    logic a;
    for (int j = 0; j < W; j++) px[j] = DW'($urandom);
    for (int c = 0; c < N; c++) begin
      iData = px[i < W ? i : W - 1];
      iDval = i < W;
      @(negedge iclk);
      a = iDval && oRdy;
      if (oData_en) seen++;
      if (seen == 2 * W + 2) break;
      @(posedge iclk);
      #1;
      if (a) i++;
    end
    iDval = 1'b0;
    irst_n = 1'b0;
    #1;
    n_chk += 5;
    if (seen != 2 * W + 2) begin n_fail++; $display("FAIL midrst_reach_replay: got %0d outputs expected %0d", seen, 2 * W + 2); end
    if (oData_en !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %b expected 0", oData_en); end
    if (oData !== '0) begin n_fail++; $display("FAIL midrst_data: got %0d expected 0", oData); end
    if (oRdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy: got %b expected 0", oRdy); end
    if (oFrame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", oFrame_done); end
    frame_row = 0;
    repeat (2) @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk);
    #1;
    for (int j = 0; j < W; j++) px[j] = DW'($urandom);
    build_exp();
    run_row(1'b0);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_chk++;
      if (j >= got.size() || got[j] != exp_q[j]) begin
        n_fail++;
        $display("FAIL midrst_pix[%0d]: got %0d expected %0d", j, j < got.size() ? got[j] : -1, exp_q[j]);
      end
    end
    n_chk += 3;
    if (got.size() != 4 * W) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", got.size(), 4 * W); end
    if (n_done != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", n_done); end
    if (acc_at.size() < 2 || out_at.size() == 0 || out_at[0] != acc_at[1] + 1) begin
      n_fail++;
      $display("FAIL midrst_first_out: got cycle %0d expected %0d", out_at.size() > 0 ? out_at[0] : -1, acc_at.size() > 1 ? acc_at[1] + 1 : -1);
    end
    frame_row = (frame_row + 1) % H;
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_rounding();
    test_frame_end();
    test_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
